tcm_mem_arb: RTL and testbench

- Two-requester arbiter that shares port 0 of the 32x64 dual-port TCM RAM (`tcm_mem_ram`) between requester A (fetch side) and requester B (load/store/debug side).
- Each requester gets a valid/accept handshake, byte-masked writes and fixed one-cycle read responses.
- Port 1 of the RAM is owned elsewhere and is not touched.
- Drives the RAM's active-low csb0/web0 pins combinationally, so the RAM's own posedge input registers capture the granted request.

---
 rtl/tcm_mem_arb_pkg.sv | 19 +
 rtl/tcm_mem_arb_if.sv | 30 +++
 rtl/tcm_mem_arb_rr2.sv | 45 ++++
 rtl/tcm_mem_arb.sv | 152 +++++++++++++++
 tb/tb_tcm_mem_arb.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tcm_mem_arb_pkg.sv
// Shared types and defaults for the TCM port-0 arbiter.
package tcm_mem_arb_pkg;

    localparam int TCM_ADDR_W  = 5;
    localparam int TCM_DATA_W  = 64;
    localparam int TCM_WMASK_W = 8;

    // INIT only exists when TCM_MEM_ARB_INIT_EN is defined.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/tcm_mem_arb_if.sv
// One requester port of the TCM arbiter: valid/accept request channel
// plus an unbackpressured one-cycle read response.
interface tcm_mem_arb_if
    import tcm_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = TCM_ADDR_W,
    parameter int DATA_WIDTH = TCM_DATA_W,
    parameter int NUM_WMASKS = TCM_WMASK_W
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NUM_WMASKS-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  accept;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Requester side.
    modport master (
        output req, we, addr, wmask, wdata,
        input  accept, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wmask, wdata,
        output accept, rsp_valid, rsp_data
    );
endinterface

// File: rtl/tcm_mem_arb_rr2.sv
// Two-way round-robin picker. The last-grant register starts at B so A
// wins the first contention, and it only moves on an actual grant.
module tcm_mem_arb_rr2
    import tcm_mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    req_id_e last_q;
    req_id_e last_d;

    // Pick a winner this cycle and compute the new last-grant owner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        last_d  = last_q;
        if (en_i) begin
            if (req_a_i && (!req_b_i || last_q == REQ_B)) begin
                gnt_a_o = 1'b1;
                last_d  = REQ_A;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
                last_d  = REQ_B;
            end
        end
    end

    // Last-grant register.
    always_ff @(posedge clk_i) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            last_q <= REQ_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/tcm_mem_arb.sv
// Arbiter sharing port 0 of the 32x64 TCM RAM between requester A
// (fetch) and requester B (load/store/debug). RAM pins are driven
// combinationally so the RAM's own input registers capture the grant.
// Optional: TCM_MEM_ARB_INIT_EN adds an INIT state that zero-fills the
// RAM after reset before any request is accepted.
module tcm_mem_arb
    import tcm_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = TCM_ADDR_W,
    parameter int DATA_WIDTH = TCM_DATA_W,
    parameter int NUM_WMASKS = TCM_WMASK_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tcm_mem_arb_if.slave          a_if,
    tcm_mem_arb_if.slave          b_if,
    output logic                  ram_csb0_o,
    output logic                  ram_web0_o,
    output logic [ADDR_WIDTH-1:0] ram_addr0_o,
    output logic [NUM_WMASKS-1:0] ram_wmask0_o,
    output logic [DATA_WIDTH-1:0] ram_din0_o,
    input  logic [DATA_WIDTH-1:0] ram_dout0_i,
    output logic                  init_done_o
);

    logic                  run_en;
    logic                  init_active;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  gnt_a;
    logic                  gnt_b;

    logic                  a_rsp_q, a_rsp_d;
    logic                  b_rsp_q, b_rsp_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  csb;
    logic                  web;

`ifdef TCM_MEM_ARB_INIT_EN
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // INIT walks the counter over every word, then hands over to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    // State and fill-counter registers; reset restarts the fill at 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_active = (state_q == ST_INIT) && !rst_i;
    assign run_en      = (state_q == ST_RUN) && !rst_i;
    assign init_addr   = cnt_q;
`else
    assign init_active = 1'b0;
    assign run_en      = !rst_i;
    assign init_addr   = '0;
`endif

    assign init_done_o = run_en;

    tcm_mem_arb_rr2 u_rr2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (run_en),
        .req_a_i (a_if.req),
        .req_b_i (b_if.req),
        .gnt_a_o (gnt_a),
        .gnt_b_o (gnt_b)
    );

    // Mux the winner onto the RAM pins; with no access the bus holds its last value.
    always_comb begin
        csb     = 1'b1;
        web     = 1'b1;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        din_d   = din_q;
        if (init_active) begin
            csb     = 1'b0;
            web     = 1'b0;
            addr_d  = init_addr;
            wmask_d = '1;
            din_d   = '0;
        end else if (gnt_a) begin
            csb     = 1'b0;
            web     = !a_if.we;
            addr_d  = a_if.addr;
            wmask_d = a_if.we ? a_if.wmask : '1;
            din_d   = a_if.we ? a_if.wdata : '0;
        end else if (gnt_b) begin
            csb     = 1'b0;
            web     = !b_if.we;
            addr_d  = b_if.addr;
            wmask_d = b_if.we ? b_if.wmask : '1;
            din_d   = b_if.we ? b_if.wdata : '0;
        end
        a_rsp_d = gnt_a && !a_if.we;
        b_rsp_d = gnt_b && !b_if.we;
    end

    // Response-valid flags and the held RAM bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
            // NOTE: the held bus is reset only so it is never X; the RAM array itself is never reset here.
            addr_q  <= '0;
            wmask_q <= '0;
            din_q   <= '0;
        end else begin
            a_rsp_q <= a_rsp_d;
            b_rsp_q <= b_rsp_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            din_q   <= din_d;
        end
    end

    assign ram_csb0_o   = csb;
    assign ram_web0_o   = web;
    assign ram_addr0_o  = addr_d;
    assign ram_wmask0_o = wmask_d;
    assign ram_din0_o   = din_d;

    assign a_if.accept    = gnt_a;
    assign a_if.rsp_valid = a_rsp_q;
    assign a_if.rsp_data  = ram_dout0_i;
    assign b_if.accept    = gnt_b;
    assign b_if.rsp_valid = b_rsp_q;
    assign b_if.rsp_data  = ram_dout0_i;

endmodule

// File: tb/tb_tcm_mem_arb.sv
// Bench for tcm_mem_arb with a behavioural model of the TCM RAM port 0
// (inputs registered at posedge, write and read at the following negedge).
module tb_tcm_mem_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ram_csb0, ram_web0;
    logic [4:0]  ram_addr0;
    logic [7:0]  ram_wmask0;
    logic [63:0] ram_din0;
    logic [63:0] ram_dout0;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    tcm_mem_arb_if a_if ();
    tcm_mem_arb_if b_if ();

    tcm_mem_arb dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .a_if         (a_if),
        .b_if         (b_if),
        .ram_csb0_o   (ram_csb0),
        .ram_web0_o   (ram_web0),
        .ram_addr0_o  (ram_addr0),
        .ram_wmask0_o (ram_wmask0),
        .ram_din0_o   (ram_din0),
        .ram_dout0_i  (ram_dout0),
        .init_done_o  (init_done)
    );

    always #5 clk = ~clk;

    // RAM model.
    logic [63:0] mem [32];
    logic        csb_r, web_r;
    logic [4:0]  addr_r;
    logic [7:0]  wm_r;
    logic [63:0] din_r;

    always @(posedge clk) begin
        csb_r  <= ram_csb0;
        web_r  <= ram_web0;
        addr_r <= ram_addr0;
        wm_r   <= ram_wmask0;
        din_r  <= ram_din0;
    end

    always @(negedge clk) begin
        if (csb_r === 1'b0 && web_r === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                if (wm_r[i]) mem[addr_r][i*8 +: 8] <= din_r[i*8 +: 8];
            end
        end
        if (csb_r === 1'b0 && web_r === 1'b1) ram_dout0 <= mem[addr_r];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [4:0] aa, input logic [7:0] am,
                         input logic [63:0] ad, input logic br, input logic bw, input logic [4:0] ba,
                         input logic [7:0] bm, input logic [63:0] bd);
        a_if.req = ar; a_if.we = aw; a_if.addr = aa; a_if.wmask = am; a_if.wdata = ad;
        b_if.req = br; b_if.we = bw; b_if.addr = ba; b_if.wmask = bm; b_if.wdata = bd;
    endtask

    // Advance to the next cycle's input phase / sampling phase.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic        a_req, a_we;
        logic [4:0]  a_addr;
        logic [7:0]  a_wm;
        logic [63:0] a_wd;
        logic        b_req, b_we;
        logic [4:0]  b_addr;
        logic [7:0]  b_wm;
        logic [63:0] b_wd;
        logic        e_aacc, e_bacc, e_arv, e_brv;
        logic [63:0] e_data;
        logic        e_csb, e_web;
        logic [4:0]  e_addr;
        logic [7:0]  e_wm;
        logic [63:0] e_din;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [4:0]  A0 = 5'd0, A1 = 5'd1, A3 = 5'd3, A5 = 5'd5, A7 = 5'd7, A9 = 5'd9;
    localparam logic [7:0]  MFF = 8'hFF, M0F = 8'h0F, M01 = 8'h01, M00 = 8'h00;
    localparam logic [63:0] Z   = 64'h0;
    localparam logic [63:0] D3  = 64'hDEADBEEF_01234567;
    localparam logic [63:0] DF  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] W4  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] M5  = 64'hFFFF_FFFF_3333_4444;
    localparam logic [63:0] D55 = 64'h55;
    localparam logic [63:0] DAB = 64'hAB;
    localparam logic [63:0] DCF = 64'hCAFE;

`ifdef TCM_MEM_ARB_INIT_EN
    localparam int EXP_INIT_CYCLES = 32;
`else
    localparam int EXP_INIT_CYCLES = 0;
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        //           A: req we addr wm  wd    B: req we addr wm  wd    exp: aacc bacc arv brv data  csb web addr wm  din
        vecs[0]  = '{N, N, A0, M00, Z,   Y, Y, A3, MFF, D3,  N, Y, N, N, Z,   N, N, A3, MFF, D3};
        vecs[1]  = '{N, N, A0, M00, Z,   Y, Y, A5, MFF, DF,  N, Y, N, N, Z,   N, N, A5, MFF, DF};
        vecs[2]  = '{Y, N, A3, M00, Z,   N, N, A0, M00, Z,   Y, N, N, N, Z,   N, Y, A3, MFF, Z};
        vecs[3]  = '{N, N, A0, M00, Z,   N, N, A0, M00, Z,   N, N, Y, N, D3,  Y, Y, A3, MFF, Z};
        vecs[4]  = '{N, N, A0, M00, Z,   Y, Y, A5, M0F, W4,  N, Y, N, N, Z,   N, N, A5, M0F, W4};
        vecs[5]  = '{N, N, A0, M00, Z,   Y, N, A5, MFF, Z,   N, Y, N, N, Z,   N, Y, A5, MFF, Z};
        vecs[6]  = '{N, N, A0, M00, Z,   N, N, A0, M00, Z,   N, N, N, Y, M5,  Y, Y, A5, MFF, Z};
        vecs[7]  = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   Y, N, N, N, Z,   N, Y, A3, MFF, Z};
        vecs[8]  = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   N, Y, Y, N, D3,  N, Y, A5, MFF, Z};
        vecs[9]  = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   Y, N, N, Y, M5,  N, Y, A3, MFF, Z};
        vecs[10] = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   N, Y, Y, N, D3,  N, Y, A5, MFF, Z};
        vecs[11] = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   Y, N, N, Y, M5,  N, Y, A3, MFF, Z};
        vecs[12] = '{Y, N, A3, MFF, Z,   Y, N, A5, MFF, Z,   N, Y, Y, N, D3,  N, Y, A5, MFF, Z};
        vecs[13] = '{Y, Y, A9, MFF, D55, N, N, A0, M00, Z,   Y, N, N, Y, M5,  N, N, A9, MFF, D55};
        vecs[14] = '{N, N, A0, M00, Z,   Y, N, A9, MFF, Z,   N, Y, N, N, Z,   N, Y, A9, MFF, Z};
        vecs[15] = '{N, N, A0, M00, Z,   N, N, A0, M00, Z,   N, N, N, Y, D55, Y, Y, A9, MFF, Z};
        vecs[16] = '{Y, N, A3, M00, DCF, N, N, A0, M00, Z,   Y, N, N, N, Z,   N, Y, A3, MFF, Z};
        vecs[17] = '{Y, Y, A1, M01, DAB, Y, N, A3, MFF, Z,   N, Y, Y, N, D3,  N, Y, A3, MFF, Z};
        vecs[18] = '{Y, Y, A1, M01, DAB, N, N, A0, M00, Z,   Y, N, N, Y, D3,  N, N, A1, M01, DAB};
        vecs[19] = '{N, N, A0, M00, Z,   N, N, A0, M00, Z,   N, N, N, N, Z,   Y, Y, A1, M01, DAB};

        // Reset state.
        rst_i = 1'b1;
        drive(N, N, A0, M00, Z, N, N, A0, M00, Z);
        repeat (3) next_cycle();
        sample_point();
        check("rst_csb", ram_csb0, Y);
        check("rst_web", ram_web0, Y);
        check("rst_aacc", a_if.accept, N);
        check("rst_bacc", b_if.accept, N);
        check("rst_arv", a_if.rsp_valid, N);
        check("rst_brv", b_if.rsp_valid, N);

        // Release reset and measure the delay to init_done.
        next_cycle();
        rst_i = 1'b0;
        n = 0;
        sample_point();
        while (init_done !== 1'b1 && n < 100) begin
            n++;
            next_cycle();
            sample_point();
        end
        check("init_cycles", 64'(n), 64'(EXP_INIT_CYCLES));

        // Table of single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wm, vecs[i].a_wd,
                  vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wm, vecs[i].b_wd);
            sample_point();
            check($sformatf("r%0d_aacc", i), a_if.accept, vecs[i].e_aacc);
            check($sformatf("r%0d_bacc", i), b_if.accept, vecs[i].e_bacc);
            check($sformatf("r%0d_arv", i), a_if.rsp_valid, vecs[i].e_arv);
            check($sformatf("r%0d_brv", i), b_if.rsp_valid, vecs[i].e_brv);
            if (vecs[i].e_arv) check($sformatf("r%0d_adata", i), a_if.rsp_data, vecs[i].e_data);
            if (vecs[i].e_brv) check($sformatf("r%0d_bdata", i), b_if.rsp_data, vecs[i].e_data);
            check($sformatf("r%0d_csb", i), ram_csb0, vecs[i].e_csb);
            check($sformatf("r%0d_web", i), ram_web0, vecs[i].e_web);
            check($sformatf("r%0d_addr", i), ram_addr0, vecs[i].e_addr);
            check($sformatf("r%0d_wmask", i), ram_wmask0, vecs[i].e_wm);
            check($sformatf("r%0d_din", i), ram_din0, vecs[i].e_din);
        end

`ifdef TCM_MEM_ARB_INIT_EN
        // A word never written by the requesters reads back as zero after INIT.
        next_cycle();
        drive(Y, N, A7, MFF, Z, N, N, A0, M00, Z);
        sample_point();
        check("init_rd7_acc", a_if.accept, Y);
        next_cycle();
        drive(N, N, A0, M00, Z, N, N, A0, M00, Z);
        sample_point();
        check("init_rd7_rv", a_if.rsp_valid, Y);
        check("init_rd7_data", a_if.rsp_data, Z);
`endif

        // Reset in the cycle after an accepted read.
        next_cycle();
        drive(Y, N, A3, MFF, Z, N, N, A0, M00, Z);
        sample_point();
        check("mid_acc", a_if.accept, Y);
        next_cycle();
        rst_i = 1'b1;
        sample_point();
        check("mid_rst_aacc", a_if.accept, N);
        check("mid_rst_csb", ram_csb0, Y);
        next_cycle();
        rst_i = 1'b0;
        drive(N, N, A0, M00, Z, N, N, A0, M00, Z);
        sample_point();
        check("mid_arv_cleared", a_if.rsp_valid, N);
`ifdef TCM_MEM_ARB_INIT_EN
        check("mid_init_csb", ram_csb0, N);
        check("mid_init_web", ram_web0, N);
        check("mid_init_addr", ram_addr0, A0);
        check("mid_init_done", init_done, N);
`else
        check("mid_csb", ram_csb0, Y);
        check("mid_init_done", init_done, Y);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
